// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with stall/bubble/flush, MADD feedback and bubble counter
// All outputs are registered; flush > bubble > hold > advance.
module ex_mem_stage #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int OPW     = 8,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int CW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic [AW-1:0]      ex_wd,
  input  logic               ex_wreg,
  input  logic [DW-1:0]      ex_wdata,
  input  logic [DW-1:0]      ex_hi,
  input  logic [DW-1:0]      ex_lo,
  input  logic               ex_whilo,
  input  logic [OPW-1:0]     ex_aluop,
  input  logic [DW-1:0]      ex_mem_addr,
  input  logic [DW-1:0]      ex_reg2,
  input  logic [2*DW-1:0]    hilo_i,
  input  logic [1:0]         cnt_i,
  output logic               mem_valid,
  output logic [AW-1:0]      mem_wd,
  output logic               mem_wreg,
  output logic [DW-1:0]      mem_wdata,
  output logic [DW-1:0]      mem_hi,
  output logic [DW-1:0]      mem_lo,
  output logic               mem_whilo,
  output logic [OPW-1:0]     mem_aluop,
  output logic [DW-1:0]      mem_mem_addr,
  output logic [DW-1:0]      mem_reg2,
  output logic [2*DW-1:0]    hilo_o,
  output logic [1:0]         cnt_o,
  output logic [CW-1:0]      bubble_cnt
);

  localparam logic [AW-1:0]  NOP_REG_ADDR  = '0;
  localparam logic [OPW-1:0] EXE_NOP_OP    = '0;
  localparam logic           WRITE_DISABLE = 1'b0;

  logic w_ex_stall;
  logic w_mem_stall;
  logic w_cnt_max;

  assign w_ex_stall  = stall[STAGE];
  assign w_mem_stall = stall[STAGE+1];
  assign w_cnt_max   = &bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid    <= 1'b0;
      mem_wd       <= NOP_REG_ADDR;
      mem_wreg     <= WRITE_DISABLE;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WRITE_DISABLE;
      mem_aluop    <= EXE_NOP_OP;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= '0;
      cnt_o        <= '0;
      bubble_cnt   <= '0;
    end else if (flush) begin
      // bubble_cnt is a performance counter and survives flushes
      mem_valid    <= 1'b0;
      mem_wd       <= NOP_REG_ADDR;
      mem_wreg     <= WRITE_DISABLE;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WRITE_DISABLE;
      mem_aluop    <= EXE_NOP_OP;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end else if (w_ex_stall && !w_mem_stall) begin
      mem_valid    <= 1'b0;
      mem_wd       <= NOP_REG_ADDR;
      mem_wreg     <= WRITE_DISABLE;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= WRITE_DISABLE;
      mem_aluop    <= EXE_NOP_OP;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= hilo_i;
      cnt_o        <= cnt_i;
      if (!w_cnt_max) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end else if (!w_ex_stall) begin
      // an illegal EX-run/MEM-stall pattern also lands here and advances
      mem_valid    <= ex_valid;
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_whilo    <= ex_whilo;
      mem_aluop    <= ex_aluop;
      mem_mem_addr <= ex_mem_addr;
      mem_reg2     <= ex_reg2;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage
// Expected state is pushed per cycle and popped after the clock edge.
module tb_ex_mem_stage;

  localparam int DW = 32, AW = 5, OPW = 8, STALL_W = 6, STAGE = 3, CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [STALL_W-1:0] stall = '0;
  logic flush = 1'b0;
  logic ex_valid = 1'b0;
  logic [AW-1:0] ex_wd = '0;
  logic ex_wreg = 1'b0;
  logic [DW-1:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0, ex_mem_addr = '0, ex_reg2 = '0;
  logic ex_whilo = 1'b0;
  logic [OPW-1:0] ex_aluop = '0;
  logic [2*DW-1:0] hilo_i = '0;
  logic [1:0] cnt_i = '0;

  logic mem_valid, mem_wreg, mem_whilo;
  logic [AW-1:0] mem_wd;
  logic [DW-1:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [OPW-1:0] mem_aluop;
  logic [2*DW-1:0] hilo_o;
  logic [1:0] cnt_o;
  logic [CW-1:0] bubble_cnt;

  ex_mem_stage #(.DW(DW), .AW(AW), .OPW(OPW), .STALL_W(STALL_W), .STAGE(STAGE), .CW(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            valid, wreg, whilo;
    logic [AW-1:0]   wd;
    logic [DW-1:0]   wdata, hi, lo, addr, reg2;
    logic [OPW-1:0]  aluop;
    logic [2*DW-1:0] hilo;
    logic [1:0]      cnt;
    logic [CW-1:0]   bcnt;
  } st_t;

  st_t m;
  st_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic st_t zero_st();
    st_t z;
    z.valid = 0; z.wreg = 0; z.whilo = 0; z.wd = '0; z.wdata = '0; z.hi = '0; z.lo = '0;
    z.addr = '0; z.reg2 = '0; z.aluop = '0; z.hilo = '0; z.cnt = '0; z.bcnt = '0;
    return z;
  endfunction

  function automatic st_t clear_pipe(input st_t s);
    st_t z = zero_st();
    z.hilo = s.hilo; z.cnt = s.cnt; z.bcnt = s.bcnt;
    return z;
  endfunction

  function automatic st_t model_next(input st_t s);
    st_t n = s;
    if (flush) begin
      n = clear_pipe(s);
      n.hilo = '0; n.cnt = '0;
    end else if (stall[STAGE] && !stall[STAGE+1]) begin
      n = clear_pipe(s);
      n.hilo = hilo_i; n.cnt = cnt_i;
      n.bcnt = (s.bcnt == 2'd3) ? 2'd3 : s.bcnt + 2'd1;
    end else if (!stall[STAGE]) begin
      n.valid = ex_valid; n.wd = ex_wd; n.wreg = ex_wreg; n.wdata = ex_wdata;
      n.hi = ex_hi; n.lo = ex_lo; n.whilo = ex_whilo; n.aluop = ex_aluop;
      n.addr = ex_mem_addr; n.reg2 = ex_reg2; n.hilo = '0; n.cnt = '0;
    end
    return n;
  endfunction

  task automatic cmp_all(input st_t e);
    chk("valid", 64'(mem_valid), 64'(e.valid));
    chk("wd", 64'(mem_wd), 64'(e.wd));
    chk("wreg", 64'(mem_wreg), 64'(e.wreg));
    chk("wdata", 64'(mem_wdata), 64'(e.wdata));
    chk("hi", 64'(mem_hi), 64'(e.hi));
    chk("lo", 64'(mem_lo), 64'(e.lo));
    chk("whilo", 64'(mem_whilo), 64'(e.whilo));
    chk("aluop", 64'(mem_aluop), 64'(e.aluop));
    chk("addr", 64'(mem_mem_addr), 64'(e.addr));
    chk("reg2", 64'(mem_reg2), 64'(e.reg2));
    chk("hilo", hilo_o, e.hilo);
    chk("cnt", 64'(cnt_o), 64'(e.cnt));
    chk("bcnt", 64'(bubble_cnt), 64'(e.bcnt));
  endtask

  task automatic step();
    st_t e;
    sb.push_back(model_next(m));
    m = model_next(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      cmp_all(e);
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    m = zero_st();
    cmp_all(m);
    #1 rst = 1'b0;
  endtask

  task automatic rand_ex();
    ex_valid = 1'($urandom); ex_wd = AW'($urandom); ex_wreg = 1'($urandom);
    ex_wdata = $urandom; ex_hi = $urandom; ex_lo = $urandom; ex_whilo = 1'($urandom);
    ex_aluop = OPW'($urandom); ex_mem_addr = $urandom; ex_reg2 = $urandom;
    hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
  endtask

  always @(posedge clk) begin
    if (!rst) assert (!(!stall[STAGE] && stall[STAGE+1]))
      else $error("FAIL illegal_stall stall=%b", stall);
  end

  initial begin
    logic [CW-1:0] sat_seq [5];
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    m = zero_st();
    #3;
    cmp_all(m);
    chk("rst_wd", 64'(mem_wd), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    ex_valid = 1; ex_wd = 5; ex_wdata = 32'h1234_5678; ex_wreg = 1;
    step();
    chk("adv_wd", 64'(mem_wd), 64'd5);
    chk("adv_wdata", 64'(mem_wdata), 64'h12345678);
    chk("adv_wreg", 64'(mem_wreg), 64'd1);

    stall = 6'b001000; hilo_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd1;
    step();
    chk("bub_wreg", 64'(mem_wreg), 64'd0);
    chk("bub_valid", 64'(mem_valid), 64'd0);
    chk("bub_hilo", hilo_o, 64'hDEADBEEF00000001);
    chk("bub_cnt", 64'(cnt_o), 64'd1);
    chk("bub_bcnt", 64'(bubble_cnt), 64'd1);
    stall = 6'b000000;
    step();
    chk("adv_hilo", hilo_o, 64'd0);
    chk("adv_cnt", 64'(cnt_o), 64'd0);

    ex_wdata = 32'hA5A5_A5A5;
    step();
    stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = $urandom;
      step();
      chk("hold_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
      chk("hold_bcnt", 64'(bubble_cnt), 64'd1);
    end

    stall = 6'b001000; hilo_i = 64'h1111_2222_3333_4444;
    step();
    stall = 6'b011000; flush = 1;
    step();
    chk("fl_wdata", 64'(mem_wdata), 64'd0);
    chk("fl_hilo", hilo_o, 64'd0);
    chk("fl_bcnt", 64'(bubble_cnt), 64'd2);
    flush = 0;

    async_reset();
    stall = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat_seq", 64'(bubble_cnt), 64'(sat_seq[i]));
    end

    async_reset();
    for (int i = 0; i < 300; i++) begin
      int r;
      rand_ex();
      r = $urandom_range(0, 9);
      flush = (r == 0);
      stall = STALL_W'($urandom);
      if (r < 5) begin stall[STAGE] = 0; stall[STAGE+1] = 0; end
      else if (r < 7) begin stall[STAGE] = 1; stall[STAGE+1] = 1; end
      else begin stall[STAGE] = 1; stall[STAGE+1] = 0; end
      step();
    end

    stall = 6'b011000; flush = 0;
    step();
    async_reset();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline register for the five-stage core; replaces the fixed 32-bit, always-advance register.
- Adds a stall-vector response (hold or bubble), synchronous flush, a valid bit, and load/store side-band.
- Adds a feedback path carrying the multi-cycle multiply-accumulate temporary (hilo/cnt) back to EX while EX stalls.
- Also adds a saturating bubble counter for performance monitoring.

Parameters:
- DW, 32, data/HI/LO width
- AW, 5, register-file address width
- OPW, 8, ALU opcode width
- STALL_W, 6, width of stall vector from the stall controller
- STAGE, 3, index of the EX stall bit; MEM stall bit is STAGE+1; legal only if STAGE+1 < STALL_W
- CW, 16, bubble-counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; asynchronous, active-high (rst==`RstEnable)
- stall  in  STALL_W  per-stage stall request from stall controller
- flush  in  1  exception/branch flush, synchronous
- ex_valid  in  1  EX holds a real instruction
- ex_wd  in  AW  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  DW  result
- ex_hi / ex_lo  in  DW each  HI/LO write data
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  OPW  opcode forwarded for MEM load/store decode
- ex_mem_addr  in  DW  computed memory address
- ex_reg2  in  DW  store data
- hilo_i  in  2*DW  MADD/MSUB partial product from EX
- cnt_i  in  2  MADD/MSUB cycle count from EX
- mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  widths as inputs  registered copies
- hilo_o  out  2*DW  partial product returned to EX
- cnt_o  out  2  cycle count returned to EX
- bubble_cnt  out  CW  number of bubbles inserted, saturating

Behaviour:
- All outputs are registers; nothing combinational from inputs.
- Reset (async, rst=1): every output = 0. mem_wd = `NOPRegAddr; enables = `WriteDisable; aluop = `EXE_NOP_OP.
- On each rising edge with rst=0, evaluate in strict priority:
  1. FLUSH (flush=1): load the reset values into all pipeline outputs, hilo_o and cnt_o. bubble_cnt is unchanged. Flush overrides any stall.
  2. BUBBLE (stall[STAGE]=1, stall[STAGE+1]=0): load reset values into all mem_* outputs, including mem_valid=0. Capture hilo_o<=hilo_i and cnt_o<=cnt_i. bubble_cnt increments by 1, saturating at 2^CW-1.
  3. HOLD (stall[STAGE]=1, stall[STAGE+1]=1): every output keeps its value, including hilo_o, cnt_o and bubble_cnt.
  4. ADVANCE (stall[STAGE]=0): mem_* <= ex_* and mem_valid<=ex_valid. hilo_o<=0, cnt_o<=0.
- stall[STAGE]=0 with stall[STAGE+1]=1 is illegal from the controller. The block treats it as ADVANCE; the verification environment flags it with an assertion.
- Latency: one cycle EX->MEM on ADVANCE. hilo/cnt feedback is one cycle, captured only in BUBBLE.
- bubble_cnt is cleared only by rst. At saturation it stays at 2^CW-1 and does not wrap.
- Reset asserted mid-HOLD or mid-MADD: all state, including the partial product, is lost immediately. No recovery is attempted.
- ex_* inputs are not qualified by ex_valid; an invalid instruction still propagates its fields, and MEM gates on mem_valid.

Test Plan:
- Reset: rst=1 asynchronously between edges -> all outputs 0 within the same cycle, mem_wd=0, bubble_cnt=0; deassert, no stall, ex_wd=5, ex_wdata=32'h1234_5678, ex_wreg=1 -> next edge mem_wd=5, mem_wdata=32'h12345678, mem_wreg=1.
- Bubble + MADD: stall=6'b001000, hilo_i=64'hDEAD_BEEF_0000_0001, cnt_i=1 -> mem_wreg=0, mem_valid=0, hilo_o=64'hDEADBEEF00000001, cnt_o=1, bubble_cnt=1; next ADVANCE -> hilo_o=0, cnt_o=0.
- Hold: load mem_wdata=32'hA5A5A5A5, then stall=6'b011000 for 3 cycles while ex_wdata changes -> mem_wdata stays A5A5A5A5, bubble_cnt unchanged.
- Flush priority: flush=1 together with stall=6'b011000 -> all mem_* cleared, hilo_o=0, bubble_cnt unchanged.
- Saturation (CW=2): 5 consecutive BUBBLE cycles -> bubble_cnt sequence 1,2,3,3,3.
- Random ADVANCE/HOLD/BUBBLE/flush mix checked against a reference model; assert no illegal stall pattern was ever issued.
